// File: rtl/fifo_stream_adapter.sv
// Read stage for a synchronous FIFO with 1-cycle registered read latency; presents words on a
// valid/ready stream through a 2-entry buffer. Optional counters: define FIFO_STREAM_STATS_EN.
//
// state | meaning
// EMPTY | no buffered word, m_valid low
// ONE   | head holds a word
// TWO   | head and tail hold words; a capture can only coincide with a pop
module fifo_stream_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef FIFO_STREAM_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  xfer_count,
    output logic [CNT_WIDTH-1:0]  stall_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  inflight;
    logic                  pop;
    logic [1:0]            occ;
    logic [1:0]            pending;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [DATA_WIDTH-1:0] buf_tail;

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end

    // Encoding equals the number of buffered words.
    assign occ = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (inflight) state_nxt = ONE;
            end
            ONE: begin
                if (inflight && !pop)      state_nxt = TWO;
                else if (!inflight && pop) state_nxt = EMPTY;
            end
            TWO: begin
                if (pop && !inflight) state_nxt = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // m_ready reaches fifo_rd_en combinationally so a pop frees room in the same cycle.
    always_comb begin
        pop        = m_valid && m_ready;
        pending    = occ + {1'b0, inflight} - {1'b0, pop};
        fifo_rd_en = rst_n && !fifo_empty && (pending < 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            m_valid  <= 1'b0;
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            inflight <= fifo_rd_en;
            m_valid  <= (state_nxt != EMPTY);
            case (state)
                EMPTY: begin
                    if (inflight) buf_head <= fifo_data;
                end
                ONE: begin
                    if (inflight) begin
                        if (pop) buf_head <= fifo_data;
                        else     buf_tail <= fifo_data;
                    end
                end
                TWO: begin
                    if (pop) begin
                        buf_head <= buf_tail;
                        if (inflight) buf_tail <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_data = buf_head;

    a_no_capture_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(state == TWO && inflight && !pop)
    );

`ifdef FIFO_STREAM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count  <= '0;
            stall_count <= '0;
        end else begin
            if (pop)                 xfer_count  <= xfer_count + CNT_WIDTH'(1);
            if (m_valid && !m_ready) stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Directed bench for fifo_stream_adapter with a behavioural 16-deep FIFO (1-cycle read latency).
module tb_fifo_stream_adapter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
`ifdef FIFO_STREAM_STATS_EN
    logic [15:0] xfer_count;
    logic [15:0] stall_count;
`endif

    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] fmem [16];
    logic [4:0] fcount = 5'd0;
    logic [3:0] frp = 4'd0;
    logic [3:0] fwp = 4'd0;
    logic       f_rd;
    logic       f_wr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
`ifdef FIFO_STREAM_STATS_EN
        ,
        .xfer_count (xfer_count),
        .stall_count(stall_count)
`endif
    );

    assign fifo_empty = (fcount == 5'd0);

    // Environment FIFO; not reset with the DUT so mid-operation reset leaves its contents intact.
    always @(posedge clk) begin
        f_rd = fifo_rd_en && (fcount != 5'd0);
        f_wr = wr_en && ((fcount != 5'd16) || f_rd);
        if (f_rd) begin
            fifo_data <= fmem[frp];
            frp <= frp + 4'd1;
        end
        if (f_wr) begin
            fmem[fwp] <= wr_data;
            fwp <= fwp + 4'd1;
        end
        fcount <= fcount + 5'(f_wr) - 5'(f_rd);
    end

    task automatic test_reset;
        logic saw_rd;
        saw_rd = 1'b0;
        rst_n = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_data = 8'(i);
            #1;
            if (fifo_rd_en) saw_rd = 1'b1;
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        if (fifo_rd_en) saw_rd = 1'b1;
        n_cmp++;
        if (saw_rd !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: saw read=%0b, want 0", saw_rd); end
        n_cmp++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %0b, want 0", m_valid); end
        n_cmp++;
        if (m_data !== 8'h00) begin n_bad++; $display("FAIL reset_m_data: got %02h, want 00", m_data); end
    endtask

    task automatic test_streaming;
        int reads, beats, first_rd, first_v, first_b, last_b, rd16;
        logic empty_after;
        logic [7:0] got [16];
        reads = 0; beats = 0; first_rd = -1; first_v = -1; first_b = -1; last_b = -1; rd16 = -1;
        empty_after = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (c == rd16 + 1 && rd16 >= 0) empty_after = fifo_empty;
            if (fifo_rd_en && !fifo_empty) begin
                if (first_rd < 0) first_rd = c;
                reads++;
                if (reads == 16) rd16 = c;
            end
            if (m_valid && first_v < 0) first_v = c;
            if (m_valid && m_ready) begin
                if (beats < 16) got[beats] = m_data;
                if (first_b < 0) first_b = c;
                last_b = c;
                beats++;
            end
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (first_v - first_rd !== 2) begin n_bad++; $display("FAIL stream_latency: got %0d, want 2", first_v - first_rd); end
        n_cmp++;
        if (beats !== 16) begin n_bad++; $display("FAIL stream_beats: got %0d, want 16", beats); end
        for (int i = 0; i < 16 && i < beats; i++) begin
            n_cmp++;
            if (got[i] !== 8'(i)) begin n_bad++; $display("FAIL stream_data[%0d]: got %02h, want %02h", i, got[i], i); end
        end
        n_cmp++;
        if (last_b - first_b !== 15) begin n_bad++; $display("FAIL stream_gapless: span %0d, want 15", last_b - first_b); end
        n_cmp++;
        if (empty_after !== 1'b1) begin n_bad++; $display("FAIL stream_empty_flag: got %0b, want 1", empty_after); end
        n_cmp++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL stream_idle_valid: got %0b, want 0", m_valid); end
    endtask

    task automatic test_backpressure;
        int reads, beats, first_b, last_b;
        logic held_bad;
        logic [7:0] got [16];
        reads = 0; beats = 0; first_b = -1; last_b = -1; held_bad = 1'b0;
        m_ready = 1'b0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            wr_en = (c < 16);
            wr_data = 8'(c);
            #1;
            if (fifo_rd_en && !fifo_empty) reads++;
            if (m_valid && m_data !== 8'h00) held_bad = 1'b1;
        end
        wr_en = 1'b0;
        n_cmp++;
        if (reads !== 2) begin n_bad++; $display("FAIL bp_reads: got %0d, want 2", reads); end
        n_cmp++;
        if (held_bad !== 1'b0) begin n_bad++; $display("FAIL bp_hold: head changed=%0b, want 0", held_bad); end
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 8'h00) begin
            n_bad++; $display("FAIL bp_head: got v=%0b d=%02h, want v=1 d=00", m_valid, m_data);
        end
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (m_valid && m_ready) begin
                if (beats < 16) got[beats] = m_data;
                if (first_b < 0) first_b = c;
                last_b = c;
                beats++;
            end
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (beats !== 16) begin n_bad++; $display("FAIL bp_beats: got %0d, want 16", beats); end
        for (int i = 0; i < 16 && i < beats; i++) begin
            n_cmp++;
            if (got[i] !== 8'(i)) begin n_bad++; $display("FAIL bp_data[%0d]: got %02h, want %02h", i, got[i], i); end
        end
        n_cmp++;
        if (last_b - first_b !== 15) begin n_bad++; $display("FAIL bp_gapless: span %0d, want 15", last_b - first_b); end
    endtask

    task automatic test_underrun;
        int beats, vcyc;
        int bc [2];
        logic [7:0] got [2];
        beats = 0; vcyc = 0; bc[0] = 0; bc[1] = 0; got[0] = 8'h00; got[1] = 8'h00;
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            wr_en = (c == 0 || c == 5);
            wr_data = (c == 0) ? 8'hA5 : 8'h3C;
            #1;
            if (m_valid) vcyc++;
            if (m_valid && m_ready) begin
                if (beats < 2) begin got[beats] = m_data; bc[beats] = c; end
                beats++;
            end
        end
        wr_en = 1'b0;
        n_cmp++;
        if (beats !== 2) begin n_bad++; $display("FAIL under_beats: got %0d, want 2", beats); end
        n_cmp++;
        if (got[0] !== 8'hA5) begin n_bad++; $display("FAIL under_first: got %02h, want a5", got[0]); end
        n_cmp++;
        if (got[1] !== 8'h3C) begin n_bad++; $display("FAIL under_second: got %02h, want 3c", got[1]); end
        n_cmp++;
        if (vcyc !== 2) begin n_bad++; $display("FAIL under_valid_cycles: got %0d, want 2", vcyc); end
        n_cmp++;
        if (bc[1] - bc[0] !== 5) begin n_bad++; $display("FAIL under_spacing: got %0d, want 5", bc[1] - bc[0]); end
    endtask

    task automatic test_mid_reset;
        int beats;
        logic rd_in_reset;
        logic [7:0] got [5];
        beats = 0; rd_in_reset = 1'b0;
        m_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            wr_en = (c < 8);
            wr_data = 8'h40 + 8'(c);
            #1;
        end
        wr_en = 1'b0;
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 8'h40) begin
            n_bad++; $display("FAIL mr_pre_head: got v=%0b d=%02h, want v=1 d=40", m_valid, m_data);
        end
        // Next cycle: 0x41 buffered and 0x42 in flight on fifo_data.
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 8'h41) begin
            n_bad++; $display("FAIL mr_pre_state: got v=%0b d=%02h, want v=1 d=41", m_valid, m_data);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mr_async_valid: got %0b, want 0", m_valid); end
        n_cmp++;
        if (m_data !== 8'h00) begin n_bad++; $display("FAIL mr_async_data: got %02h, want 00", m_data); end
        repeat (3) begin
            @(negedge clk);
            #1;
            if (fifo_rd_en) rd_in_reset = 1'b1;
        end
        n_cmp++;
        if (rd_in_reset !== 1'b0) begin n_bad++; $display("FAIL mr_rd_in_reset: got %0b, want 0", rd_in_reset); end
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (m_valid && m_ready) begin
                if (beats < 5) got[beats] = m_data;
                beats++;
            end
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (beats !== 5) begin n_bad++; $display("FAIL mr_beats: got %0d, want 5", beats); end
        for (int i = 0; i < 5 && i < beats; i++) begin
            n_cmp++;
            if (got[i] !== 8'h43 + 8'(i)) begin
                n_bad++; $display("FAIL mr_data[%0d]: got %02h, want %02h", i, got[i], 8'h43 + 8'(i));
            end
        end
    endtask

`ifdef FIFO_STREAM_STATS_EN
    task automatic test_stats;
        int beats, stalls;
        beats = 0; stalls = 0;
        @(negedge clk);
        rst_n = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_data = 8'h80 + 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        n_cmp++;
        if (xfer_count !== 16'd0 || stall_count !== 16'd0) begin
            n_bad++; $display("FAIL stats_reset: got x=%0d s=%0d, want 0 0", xfer_count, stall_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (m_valid && beats == 4 && stalls < 3) begin
                m_ready = 1'b0;
                stalls++;
            end else begin
                m_ready = 1'b1;
            end
            #1;
            if (m_valid && m_ready) beats++;
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (xfer_count !== 16'd10) begin n_bad++; $display("FAIL stats_xfer: got %0d, want 10", xfer_count); end
        n_cmp++;
        if (stall_count !== 16'd3) begin n_bad++; $display("FAIL stats_stall: got %0d, want 3", stall_count); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_underrun();
        test_mid_reset();
`ifdef FIFO_STREAM_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
